// File: rtl/mac_accum.sv
//------------------------------------------------------------------------------
// Module   : mac_accum
// Brief    : Accumulate stage of a MAC datapath; sums NTERMS products and
//            hands the result downstream over a valid/ready handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_accum #(
  parameter int DATAWIDTH = 8,
  parameter int NTERMS    = 4,
  parameter int CNTWIDTH  = 3
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 clear,
  input  logic                 prod_valid,
  input  logic [DATAWIDTH-1:0] prod,
  output logic                 prod_ready,
  output logic [DATAWIDTH-1:0] acc,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [CNTWIDTH-1:0]  count,
  output logic                 ovf
);

  localparam logic [CNTWIDTH-1:0] c_last = CNTWIDTH'(NTERMS - 1);
  localparam logic [CNTWIDTH-1:0] c_full = CNTWIDTH'(NTERMS);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATAWIDTH-1:0]  r_acc;
  logic [DATAWIDTH-1:0]  w_acc_nxt;
  logic [CNTWIDTH-1:0]   r_cnt;
  logic [CNTWIDTH-1:0]   w_cnt_nxt;
  logic                  r_ovf;
  logic                  w_ovf_nxt;
  logic [DATAWIDTH:0]    w_sum;

  // Extra top bit captures the carry that the wrapped accumulator loses.
  assign w_sum = {1'b0, r_acc} + {1'b0, prod};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    if (clear) begin
      w_state_nxt = ST_ACCUM;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (prod_valid) begin
            w_acc_nxt = w_sum[DATAWIDTH-1:0];
            w_ovf_nxt = r_ovf | w_sum[DATAWIDTH];
            if (r_cnt == c_last) begin
              w_cnt_nxt   = c_full;
              w_state_nxt = ST_HOLD;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (acc_ready) begin
            w_state_nxt = ST_ACCUM;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  assign prod_ready = (r_state == ST_ACCUM) && !clear;
  assign acc_valid  = (r_state == ST_HOLD);
  assign acc        = r_acc;
  assign count      = r_cnt;
  assign ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_accum.sv
//------------------------------------------------------------------------------
// Module   : tb_mac_accum
// Brief    : Self-checking bench for mac_accum against a sum-of-terms model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_accum;

  localparam int DATAWIDTH = 8;
  localparam int NTERMS    = 4;
  localparam int CNTWIDTH  = 3;

  logic                 Clk = 1'b0;
  logic                 Rst = 1'b1;
  logic                 clear = 1'b0;
  logic                 prod_valid = 1'b0;
  logic [DATAWIDTH-1:0] prod = '0;
  logic                 prod_ready;
  logic [DATAWIDTH-1:0] acc;
  logic                 acc_valid;
  logic                 acc_ready = 1'b0;
  logic [CNTWIDTH-1:0]  count;
  logic                 ovf;

  mac_accum #(
    .DATAWIDTH(DATAWIDTH),
    .NTERMS   (NTERMS),
    .CNTWIDTH (CNTWIDTH)
  ) u_dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .clear     (clear),
    .prod_valid(prod_valid),
    .prod      (prod),
    .prod_ready(prod_ready),
    .acc       (acc),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: the true (unbounded) sum of accepted terms, how many there are,
  // and whether a finished result is waiting for the consumer.
  int m_sum   = 0;
  int m_terms = 0;
  bit m_hold  = 1'b0;
  bit m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic check_model();
    check("acc",        32'(acc),        32'(m_sum % 256));
    check("count",      32'(count),      32'(m_terms));
    check("ovf",        32'(ovf),        32'(m_sum > 255));
    check("acc_valid",  32'(acc_valid),  32'(m_hold));
    check("prod_ready", 32'(prod_ready), 32'(!m_hold && !clear));
  endtask

  task automatic model_update();
    if (Rst || clear || (m_hold && acc_ready)) begin
      m_sum   = 0;
      m_terms = 0;
      m_hold  = 1'b0;
    end else if (!m_hold && prod_valid) begin
      m_sum   = m_sum + int'(prod);
      m_terms = m_terms + 1;
      if (m_terms == NTERMS) m_hold = 1'b1;
    end
    if (Rst) m_known = 1'b1;
  endtask

  // One clock: drive inputs, compare mid-cycle, advance the model on the edge.
  task automatic step(input logic r, input logic c, input logic pv,
                      input logic [DATAWIDTH-1:0] p, input logic ar);
    Rst        = r;
    clear      = c;
    prod_valid = pv;
    prod       = p;
    acc_ready  = ar;
    @(negedge Clk);
    if (m_known) check_model();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  initial begin
    logic [DATAWIDTH-1:0] vals [4];
    logic                 pvs  [7];
    logic [DATAWIDTH-1:0] gps  [7];

    // Reset
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_acc", 32'(acc), 0);
    check("rst_valid", 32'(acc_valid), 0);
    check("rst_count", 32'(count), 0);

    // Basic sum 3+5+7+9
    vals = '{8'd3, 8'd5, 8'd7, 8'd9};
    foreach (vals[i]) step(0, 0, 1, vals[i], 0);
    check("basic_acc", 32'(acc), 24);
    check("basic_count", 32'(count), 4);
    check("basic_valid", 32'(acc_valid), 1);
    check("basic_ovf", 32'(ovf), 0);
    step(0, 0, 0, 0, 1);
    check("basic_drain_acc", 32'(acc), 0);
    check("basic_drain_valid", 32'(acc_valid), 0);

    // Wrap with carry
    vals = '{8'd200, 8'd100, 8'd10, 8'd1};
    foreach (vals[i]) step(0, 0, 1, vals[i], 0);
    check("wrap_acc", 32'(acc), 55);
    check("wrap_ovf", 32'(ovf), 1);
    step(0, 0, 0, 0, 1);
    check("wrap_ovf_clr", 32'(ovf), 0);

    // Gaps, then back-pressure with a waiting product
    pvs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gps = '{8'd1, 8'd77, 8'd77, 8'd2, 8'd3, 8'd77, 8'd4};
    foreach (pvs[i]) step(0, 0, pvs[i], gps[i], 0);
    check("gap_acc", 32'(acc), 10);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'd99, 0);
    check("bp_acc", 32'(acc), 10);
    step(0, 0, 1, 8'd99, 1);
    step(0, 0, 1, 8'd99, 0);
    check("bp_next_acc", 32'(acc), 99);
    check("bp_next_count", 32'(count), 1);

    // Clear mid-sum blocks a same-cycle transfer
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 8'd10, 0);
    step(0, 0, 1, 8'd20, 0);
    step(0, 1, 1, 8'd50, 0);
    check("clr_acc", 32'(acc), 0);
    check("clr_count", 32'(count), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'd1, 0);
    check("clr_then_acc", 32'(acc), 4);

    // Clear in HOLD overrides acc_ready
    step(0, 1, 0, 0, 1);
    check("clr_hold_valid", 32'(acc_valid), 0);
    check("clr_hold_acc", 32'(acc), 0);

    // Reset mid-sum and in HOLD
    step(0, 0, 1, 8'd40, 0);
    step(0, 0, 1, 8'd41, 0);
    step(1, 0, 1, 8'd42, 0);
    check("rst_mid_acc", 32'(acc), 0);
    check("rst_mid_count", 32'(count), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'd255, 0);
    check("ff_acc", 32'(acc), 252);
    check("ff_ovf", 32'(ovf), 1);
    step(1, 0, 1, 8'd5, 1);
    check("rst_hold_valid", 32'(acc_valid), 0);
    check("rst_hold_ovf", 32'(ovf), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [DATAWIDTH-1:0] p;
      p = ($urandom_range(0, 3) == 0) ? DATAWIDTH'($urandom_range(192, 255))
                                      : DATAWIDTH'($urandom);
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0,
           p,
           $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
